// File: rtl/rob_commit.sv
// rob_commit: circular reorder buffer retiring out-of-order completions in program order
// to the architectural register file write port.
module rob_commit #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_dest,
  input  logic             alloc_wen,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cmpl_valid,
  input  logic [TAG_W-1:0] cmpl_tag,
  input  logic [31:0]      cmpl_data,
  input  logic             flush,
  output logic             regwrite,
  output logic [4:0]       writereg,
  output logic [31:0]      writedata,
  output logic             commit_valid,
  output logic [TAG_W:0]   count,
  output logic             empty,
  output logic             full
);
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, wen_q;
  logic [4:0]       dest_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             regwrite_q, commit_valid_q;
  logic [4:0]       writereg_q;
  logic [31:0]      writedata_q;
  logic             alloc_fire, cmpl_fire, commit_fire;
  assign full        = count_q == (TAG_W+1)'(DEPTH);
  assign empty       = count_q == '0;
  assign count       = count_q;
  assign alloc_ready = ~full;
  assign alloc_tag   = tail_q;
  assign regwrite     = regwrite_q;
  assign commit_valid = commit_valid_q;
  assign writereg     = writereg_q;
  assign writedata    = writedata_q;
  // all three events look only at pre-edge state, so a same-cycle alloc never gets completed
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign cmpl_fire   = cmpl_valid && valid_q[cmpl_tag] && !done_q[cmpl_tag];
  assign commit_fire = valid_q[head_q] && done_q[head_q];
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end
    if (cmpl_fire) done_d[cmpl_tag] = 1'b1;
    if (commit_fire) valid_d[head_q] = 1'b0;
    head_d  = head_q + TAG_W'(commit_fire);
    tail_d  = tail_q + TAG_W'(alloc_fire);
    count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      regwrite_q     <= 1'b0;
      commit_valid_q <= 1'b0;
      writereg_q     <= '0;
      writedata_q    <= '0;
    end else if (flush) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      regwrite_q     <= 1'b0;
      commit_valid_q <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      regwrite_q     <= commit_fire && wen_q[head_q];
      commit_valid_q <= commit_fire;
      if (commit_fire) begin
        writereg_q  <= dest_q[head_q];
        writedata_q <= data_q[head_q];
      end
    end
  end
  // payload needs no reset: it is only read behind a set valid bit
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      wen_q[tail_q]  <= alloc_wen;
      dest_q[tail_q] <= alloc_dest;
    end
    if (cmpl_fire) data_q[cmpl_tag] <= cmpl_data;
  end
endmodule
